abro_multi_fsm: RTL and testbench

ABRO_MULTI_FSM -- requirements
Module: abro_multi_fsm

---
 rtl/abro_multi_fsm.sv | 103 ++++++++++
 tb/tb_abro_multi_fsm.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/abro_multi_fsm.sv
// Generalised ABRO: emit once every event bit has been seen since the last
// restart. Registered outputs, completion counter, optional auto-rearm.
module abro_multi_fsm #(
  parameter int unsigned N          = 4,
  parameter int unsigned PULSE_MODE = 1,
  parameter int unsigned AUTO_REARM = 0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r,
  input  logic [N-1:0]     ev,
  output logic             o,
  output logic [1:0]       state,
  output logic [N-1:0]     seen,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_EMIT    = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  localparam logic HOLD_O = (PULSE_MODE == 0);

  state_t           r_state, w_state_nxt;
  logic [N-1:0]     r_seen, w_seen_nxt, w_acc;
  logic             r_o, w_o_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_seen  <= '0;
      r_o     <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_seen  <= w_seen_nxt;
      r_o     <= w_o_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // o is computed for the state being entered, so it is visible in the
  // same cycle the new state is.
  always_comb begin
    w_state_nxt = r_state;
    w_seen_nxt  = r_seen;
    w_o_nxt     = r_o;
    w_cnt_nxt   = r_cnt;
    w_acc       = r_seen | ev;
    if (r) begin
      w_state_nxt = S_IDLE;
      w_seen_nxt  = '0;
      w_o_nxt     = 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_COLLECT: begin
          w_seen_nxt = w_acc;
          if (&w_acc) begin
            w_state_nxt = S_EMIT;
            w_o_nxt     = 1'b1;
            w_cnt_nxt   = r_cnt + 1'b1;
          end else if (|w_acc) begin
            w_state_nxt = S_COLLECT;
            w_o_nxt     = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_o_nxt     = 1'b0;
          end
        end
        S_EMIT: begin
          if (AUTO_REARM != 0) begin
            w_state_nxt = S_IDLE;
            w_seen_nxt  = '0;
            w_o_nxt     = 1'b0;
          end else begin
            w_state_nxt = S_HOLD;
            w_o_nxt     = HOLD_O;
          end
        end
        S_HOLD: begin
          w_state_nxt = S_HOLD;
          w_o_nxt     = HOLD_O;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_seen_nxt  = '0;
          w_o_nxt     = 1'b0;
        end
      endcase
    end
  end

  assign state    = r_state;
  assign seen     = r_seen;
  assign o        = r_o;
  assign done_cnt = r_cnt;

endmodule

// File: tb/tb_abro_multi_fsm.sv
// Bench for abro_multi_fsm: default instance driven from a vector table through
// a scoreboard, plus hold-mode and auto-rearm/wrap instances on shared inputs.
module tb_abro_multi_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, r;
  logic [3:0] ev;

  logic       o0, op, oa;
  logic [1:0] st0, stp, sta;
  logic [3:0] seen0, seenp, seena;
  logic [7:0] cnt0, cntp;
  logic [1:0] cnta;

  abro_multi_fsm u_def (
    .clk(clk), .reset(reset), .r(r), .ev(ev),
    .o(o0), .state(st0), .seen(seen0), .done_cnt(cnt0)
  );

  abro_multi_fsm #(.N(4), .PULSE_MODE(0), .AUTO_REARM(0), .CNT_W(8)) u_hold (
    .clk(clk), .reset(reset), .r(r), .ev(ev),
    .o(op), .state(stp), .seen(seenp), .done_cnt(cntp)
  );

  abro_multi_fsm #(.N(4), .PULSE_MODE(1), .AUTO_REARM(1), .CNT_W(2)) u_rearm (
    .clk(clk), .reset(reset), .r(r), .ev(ev),
    .o(oa), .state(sta), .seen(seena), .done_cnt(cnta)
  );

  typedef struct {
    logic       r;
    logic [3:0] ev;
    logic [1:0] st;
    logic [3:0] seen;
    logic       o;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic rr, logic [3:0] e, logic [1:0] s,
                              logic [3:0] sn, logic oo, logic [7:0] c);
    vec_t v;
    v.r = rr; v.ev = e; v.st = s; v.seen = sn; v.o = oo; v.cnt = c;
    return v;
  endfunction

  task automatic chk_def(input string tag, input logic [1:0] s, input logic [3:0] sn,
                         input logic oo, input logic [7:0] c);
    chk({tag, ".state"}, 32'(st0), 32'(s));
    chk({tag, ".seen"},  32'(seen0), 32'(sn));
    chk({tag, ".o"},     32'(o0), 32'(oo));
    chk({tag, ".cnt"},   32'(cnt0), 32'(c));
  endtask

  // Asserts reset with live inputs, checks the asynchronous clear, holds two
  // cycles, then releases with ev=0 on a falling edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0; r = 1'b0; ev = 4'b1111;
    #1;
    chk_def({tag, ".async"}, 2'd0, 4'b0000, 1'b0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    chk_def({tag, ".held"}, 2'd0, 4'b0000, 1'b0, 8'd0);
    chk({tag, ".hold.cnt"},  32'(cntp), 32'd0);
    chk({tag, ".rearm.cnt"}, 32'(cnta), 32'd0);
    @(negedge clk);
    ev = 4'b0000; reset = 1'b1;
  endtask

  task automatic step(input logic rr, input logic [3:0] e);
    @(negedge clk);
    r = rr; ev = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t e;
    reset = 1'b0; r = 1'b0; ev = 4'b0000;

    tbl.push_back(mk(0, 4'b0000, 2'd0, 4'b0000, 0, 8'd0));
    tbl.push_back(mk(0, 4'b0001, 2'd1, 4'b0001, 0, 8'd0));
    tbl.push_back(mk(0, 4'b0010, 2'd1, 4'b0011, 0, 8'd0));
    tbl.push_back(mk(0, 4'b0100, 2'd1, 4'b0111, 0, 8'd0));
    tbl.push_back(mk(0, 4'b1000, 2'd2, 4'b1111, 1, 8'd1));
    tbl.push_back(mk(0, 4'b0101, 2'd3, 4'b1111, 0, 8'd1));
    tbl.push_back(mk(0, 4'b1010, 2'd3, 4'b1111, 0, 8'd1));
    tbl.push_back(mk(0, 4'b1111, 2'd3, 4'b1111, 0, 8'd1));
    tbl.push_back(mk(1, 4'b1111, 2'd0, 4'b0000, 0, 8'd1));
    tbl.push_back(mk(1, 4'b1111, 2'd0, 4'b0000, 0, 8'd1));
    tbl.push_back(mk(0, 4'b1111, 2'd2, 4'b1111, 1, 8'd2));
    tbl.push_back(mk(0, 4'b0000, 2'd3, 4'b1111, 0, 8'd2));
    tbl.push_back(mk(1, 4'b0000, 2'd0, 4'b0000, 0, 8'd2));
    tbl.push_back(mk(0, 4'b0101, 2'd1, 4'b0101, 0, 8'd2));
    tbl.push_back(mk(0, 4'b0101, 2'd1, 4'b0101, 0, 8'd2));
    tbl.push_back(mk(0, 4'b1010, 2'd2, 4'b1111, 1, 8'd3));
    tbl.push_back(mk(1, 4'b0000, 2'd0, 4'b0000, 0, 8'd3));
    tbl.push_back(mk(0, 4'b0111, 2'd1, 4'b0111, 0, 8'd3));
    tbl.push_back(mk(1, 4'b1000, 2'd0, 4'b0000, 0, 8'd3));
    tbl.push_back(mk(0, 4'b0000, 2'd0, 4'b0000, 0, 8'd3));
    tbl.push_back(mk(0, 4'b1000, 2'd1, 4'b1000, 0, 8'd3));
    tbl.push_back(mk(1, 4'b0000, 2'd0, 4'b0000, 0, 8'd3));

    do_reset("rst0");

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      r = tbl[i].r; ev = tbl[i].ev;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk($sformatf("sb_empty%0d", i), 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk_def($sformatf("vec%0d", i), e.st, e.seen, e.o, e.cnt);
      end
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Reset between edges while collecting.
    step(0, 4'b0011);
    chk_def("mid.collect", 2'd1, 4'b0011, 1'b0, 8'd3);
    #2 reset = 1'b0;
    #1;
    chk_def("mid.reset", 2'd0, 4'b0000, 1'b0, 8'd0);
    @(negedge clk);
    ev = 4'b0000; reset = 1'b1;

    // Reset between edges while in EMIT.
    step(0, 4'b1111);
    chk_def("emit.pre", 2'd2, 4'b1111, 1'b1, 8'd1);
    #2 reset = 1'b0;
    #1;
    chk_def("emit.reset", 2'd0, 4'b0000, 1'b0, 8'd0);
    @(negedge clk);
    ev = 4'b0000; reset = 1'b1;

    do_reset("rst1");

    step(0, 4'b1111);
    chk("hold.emit.state", 32'(stp), 32'd2);
    chk("hold.emit.o",     32'(op),  32'd1);
    chk("rearm.emit.state", 32'(sta), 32'd2);
    chk("rearm.emit.cnt",   32'(cnta), 32'd1);
    step(0, 4'b0000);
    chk("hold.hold.state", 32'(stp), 32'd3);
    chk("hold.hold.o",     32'(op),  32'd1);
    chk("rearm.idle.state", 32'(sta), 32'd0);
    chk("rearm.idle.seen",  32'(seena), 32'd0);
    chk("rearm.idle.o",     32'(oa), 32'd0);
    step(0, 4'b0110);
    chk("hold.hold2.o",    32'(op), 32'd1);
    chk("hold.hold2.seen", 32'(seenp), 32'hF);
    step(1, 4'b0000);
    chk("hold.r.state", 32'(stp), 32'd0);
    chk("hold.r.o",     32'(op), 32'd0);
    chk("hold.r.cnt",   32'(cntp), 32'd1);

    // Completions 2..5 on the 2-bit counter: wraps to 0 at the 4th.
    for (int k = 2; k <= 5; k++) begin
      step(0, 4'b1111);
      chk($sformatf("wrap%0d.state", k), 32'(sta), 32'd2);
      chk($sformatf("wrap%0d.cnt", k), 32'(cnta), 32'(k % 4));
      step(0, 4'b0000);
      chk($sformatf("wrap%0d.idle", k), 32'(sta), 32'd0);
    end
    chk("hold.final.state", 32'(stp), 32'd3);
    chk("hold.final.o",     32'(op), 32'd1);
    chk("hold.final.cnt",   32'(cntp), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
